pp_seq_multiplier: RTL and testbench

Parametrised, multi-cycle partial-product multiplier. Generalises the fixed 2-bit combinational partial-product multipliers to WIDTH-bit operands. Accumulates PP_PER_CYCLE partial-product rows per clock, supports per-transaction signed/unsigned mode, and uses valid/ready handshakes on both sides. Sits between an operand source and a result consumer, and also serves as the golden sequential reference for generated multiplier variants.

---
 rtl/pp_seq_multiplier.sv | 126 ++++++++++++
 tb/tb_pp_seq_multiplier.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_seq_multiplier.sv
// pp_seq_multiplier
// Sequential partial-product multiplier for WIDTH-bit operands. Operands are
// reduced to magnitudes at capture, PP_PER_CYCLE shifted rows are summed into
// a 2*WIDTH accumulator each CALC cycle, and the sign is applied once in FIX.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | in_ready high; waiting for an operand handshake
//   CALC  | K cycles, each adding PP_PER_CYCLE partial-product rows
//   FIX   | single cycle; conditional negate of acc into out_p
//   DONE  | out_valid high; waiting for the consumer to take out_p
module pp_seq_multiplier #(
  parameter int WIDTH        = 8,
  parameter int PP_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p
);

  localparam int K  = WIDTH / PP_PER_CYCLE;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     acc;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic              neg;

  logic              a_neg;
  logic              b_neg;
  logic [WIDTH-1:0]  a_mag_in;
  logic [WIDTH-1:0]  b_mag_in;

  logic [PW-1:0]     a_ext;
  logic [PW-1:0]     step_sum;
  logic [WIDTH-1:0]  b_sh;
  int                base;

  // Operand magnitudes at capture; the most negative value maps onto
  // 2^(WIDTH-1), which still fits the unsigned WIDTH-bit magnitude.
  assign a_neg    = in_signed & in_a[WIDTH-1];
  assign b_neg    = in_signed & in_b[WIDTH-1];
  assign a_mag_in = a_neg ? (~in_a + WIDTH'(1)) : in_a;
  assign b_mag_in = b_neg ? (~in_b + WIDTH'(1)) : in_b;

  assign in_ready = (state == IDLE);

  // Sum of the current group of rows: row i = a_mag gated by b_mag[i], shifted by i.
  always_comb begin
    base     = int'(cnt) * PP_PER_CYCLE;
    a_ext    = {{WIDTH{1'b0}}, a_mag};
    b_sh     = b_mag >> base;
    step_sum = acc;
    for (int p = 0; p < PP_PER_CYCLE; p++) begin
      if (b_sh[0]) begin
        step_sum = step_sum + (a_ext << (base + p));
      end
      b_sh = b_sh >> 1;
    end
  end

  // Control FSM with registered result and valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      a_mag     <= '0;
      b_mag     <= '0;
      neg       <= 1'b0;
      out_valid <= 1'b0;
      out_p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_mag <= a_mag_in;
            b_mag <= b_mag_in;
            neg   <= a_neg ^ b_neg;
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= step_sum;
          if (cnt == CW'(K - 1)) begin
            state <= FIX;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIX: begin
          out_p     <= neg ? ((~acc) + PW'(1)) : acc;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_seq_multiplier.sv
// Bench for pp_seq_multiplier: four configurations (8/1, 8/4, 16/2, 2/1)
// share an operand bus; only the selected instance sees in_valid.
module tb_pp_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a_bus = '0;
  logic [15:0] b_bus = '0;
  logic        sgn = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [15:0] p0;
  logic [15:0] p1;
  logic [31:0] p2;
  logic [3:0]  p3;

  int tests  = 0;
  int failed = 0;

  int wid[4] = '{8, 8, 16, 2};
  int kk[4]  = '{8, 2, 8, 2};

  always #5 clk = ~clk;

  pp_seq_multiplier #(.WIDTH(8), .PP_PER_CYCLE(1)) u_w8p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(a_bus[7:0]), .in_b(b_bus[7:0]), .in_signed(sgn),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_p(p0));

  pp_seq_multiplier #(.WIDTH(8), .PP_PER_CYCLE(4)) u_w8p4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(a_bus[7:0]), .in_b(b_bus[7:0]), .in_signed(sgn),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_p(p1));

  pp_seq_multiplier #(.WIDTH(16), .PP_PER_CYCLE(2)) u_w16p2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a(a_bus), .in_b(b_bus), .in_signed(sgn),
    .out_valid(out_valid[2]), .out_ready(out_ready), .out_p(p2));

  pp_seq_multiplier #(.WIDTH(2), .PP_PER_CYCLE(1)) u_w2p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_a(a_bus[1:0]), .in_b(b_bus[1:0]), .in_signed(sgn),
    .out_valid(out_valid[3]), .out_ready(out_ready), .out_p(p3));

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [31:0] get_p(input int idx);
    case (idx)
      0:       return 32'(p0);
      1:       return 32'(p1);
      2:       return p2;
      default: return 32'(p3);
    endcase
  endfunction

  // Reference: interpret operands as integers and multiply, truncated to 2*w bits.
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic s);
    longint m, sa, sb, pr, mask;
    m    = longint'(1) << w;
    sa   = longint'(a) & (m - 1);
    sb   = longint'(b) & (m - 1);
    if (s) begin
      if (sa >= m / 2) sa = sa - m;
      if (sb >= m / 2) sb = sb - m;
    end
    pr   = sa * sb;
    mask = (longint'(1) << (2 * w)) - 1;
    return 32'(pr & mask);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_txn(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic s, output logic [31:0] p, output int lat);
    @(negedge clk);
    a_bus = a; b_bus = b; sgn = s;
    in_valid = '0;
    in_valid[idx] = 1'b1;
    chk("idle_in_ready", 32'(in_ready[idx]), 32'd1);
    @(posedge clk); #1;
    in_valid = '0;
    a_bus = 16'($urandom); b_bus = 16'($urandom); sgn = 1'($urandom);
    lat = 0;
    while (!out_valid[idx] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    p = get_p(idx);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_in_ready", 32'(in_ready[idx]), 32'd1);
    chk("post_hs_out_valid", 32'(out_valid[idx]), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    logic [15:0] hold;
    int          lat;
    int          seen;

    vecs[0]  = '{0, 16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01};
    vecs[1]  = '{0, 16'h0000, 16'h00C8, 1'b0, 32'h00000000};
    vecs[2]  = '{0, 16'h0080, 16'h0080, 1'b1, 32'h00004000};
    vecs[3]  = '{0, 16'h0080, 16'h007F, 1'b1, 32'h0000C080};
    vecs[4]  = '{0, 16'h00FF, 16'h0001, 1'b1, 32'h0000FFFF};
    vecs[5]  = '{0, 16'h0005, 16'h00FD, 1'b1, 32'h0000FFF1};
    vecs[6]  = '{0, 16'h0000, 16'h0080, 1'b1, 32'h00000000};
    vecs[7]  = '{1, 16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01};
    vecs[8]  = '{1, 16'h0080, 16'h007F, 1'b1, 32'h0000C080};
    vecs[9]  = '{2, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    vecs[10] = '{2, 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
    vecs[11] = '{3, 16'h0003, 16'h0003, 1'b0, 32'h00000009};
    vecs[12] = '{3, 16'h0002, 16'h0002, 1'b1, 32'h00000004};
    vecs[13] = '{3, 16'h0002, 16'h0001, 1'b1, 32'h0000000E};

    // Reset held with random inputs
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      a_bus = 16'($urandom); b_bus = 16'($urandom); sgn = 1'($urandom);
      in_valid = 4'($urandom); out_ready = 1'($urandom);
      @(posedge clk); #1;
      chk("rst_in_ready", 32'(in_ready), 32'hF);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_p0", 32'(p0), 32'h0);
      chk("rst_p2", p2, 32'h0);
    end
    @(negedge clk);
    in_valid = '0; out_ready = 1'b0;
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      run_txn(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].s, p, lat);
      chk($sformatf("vec%0d_p", i), p, vecs[i].exp);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(kk[vecs[i].idx] + 1));
    end

    // WIDTH=2 exhaustive in both modes
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++) begin
          run_txn(3, 16'(a), 16'(b), 1'(s), p, lat);
          chk($sformatf("w2_s%0d_%0dx%0d", s, a, b), p, ref_mul(2, 16'(a), 16'(b), 1'(s)));
        end

    // Random pairs against the reference
    for (int idx = 0; idx < 3; idx++) begin
      for (int n = 0; n < ((idx == 0) ? 100 : 1000); n++) begin
        logic [15:0] ra, rb;
        logic        rs;
        ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
        run_txn(idx, ra, rb, rs, p, lat);
        chk($sformatf("rand%0d_p a=%0h b=%0h s=%0d", idx, ra, rb, rs), p,
            ref_mul(wid[idx], ra, rb, rs));
        chk($sformatf("rand%0d_lat", idx), 32'(lat), 32'(kk[idx] + 1));
      end
    end

    // Backpressure: out_ready low for 5 cycles while inputs churn
    @(negedge clk);
    a_bus = 16'h0012; b_bus = 16'h0034; sgn = 1'b0; in_valid = 4'b0001;
    @(posedge clk); #1;
    in_valid = '0;
    lat = 0;
    while (!out_valid[0] && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("bp_lat", 32'(lat), 32'd9);
    chk("bp_p", 32'(p0), 32'h000003A8);
    hold = p0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid[0] = 1'($urandom);
      a_bus = 16'($urandom); b_bus = 16'($urandom); sgn = 1'($urandom);
      @(posedge clk); #1;
      chk("bp_stable_p", 32'(p0), 32'(hold));
      chk("bp_valid_held", 32'(out_valid[0]), 32'd1);
      chk("bp_in_ready_low", 32'(in_ready[0]), 32'd0);
    end
    @(negedge clk);
    in_valid = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_in_ready", 32'(in_ready[0]), 32'd1);
    chk("bp_release_valid", 32'(out_valid[0]), 32'd0);
    chk("bp_p_held_after_hs", 32'(p0), 32'(hold));
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen++;
    end
    chk("bp_no_spurious_accept", 32'(seen), 32'd0);

    // out_ready high before out_valid: DONE lasts exactly one cycle
    @(negedge clk);
    out_ready = 1'b1;
    a_bus = 16'h0007; b_bus = 16'h0009; sgn = 1'b0; in_valid = 4'b0001;
    @(posedge clk); #1;
    in_valid = '0;
    lat = 0;
    while (!out_valid[0] && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("early_rdy_lat", 32'(lat), 32'd9);
    chk("early_rdy_p", 32'(p0), 32'd63);
    @(posedge clk); #1;
    chk("early_rdy_done_1cyc", 32'(out_valid[0]), 32'd0);
    chk("early_rdy_in_ready", 32'(in_ready[0]), 32'd1);
    out_ready = 1'b0;

    // Asynchronous reset mid-cycle while in DONE
    @(negedge clk);
    a_bus = 16'h00FF; b_bus = 16'h00FF; sgn = 1'b0; in_valid = 4'b0001;
    @(posedge clk); #1;
    in_valid = '0;
    lat = 0;
    while (!out_valid[0] && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("async_pre_valid", 32'(out_valid[0]), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid[0]), 32'd0);
    chk("async_p0", 32'(p0), 32'd0);
    chk("async_in_ready", 32'(in_ready[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during CALC step 3 drops the transaction
    @(negedge clk);
    a_bus = 16'h00FF; b_bus = 16'h00FF; sgn = 1'b0; in_valid = 4'b0001;
    @(posedge clk); #1;
    in_valid = '0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen++;
    end
    chk("calc_rst_no_valid", 32'(seen), 32'd0);
    run_txn(0, 16'h0007, 16'h0006, 1'b0, p, lat);
    chk("calc_rst_next_p", p, 32'd42);
    chk("calc_rst_next_lat", 32'(lat), 32'd9);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
